// File: rtl/zone_mean_stream.sv
// Per-zone RGB mean engine: accumulates one frame into a ZONES_X x ZONES_Y grid,
// divides each zone sum exactly by its pixel count and streams the truncated means out.
module zone_mean_stream #(
  parameter int IMG_W   = 1920,
  parameter int IMG_H   = 1080,
  parameter int ZONES_X = 4,
  parameter int ZONES_Y = 4,
  parameter int PIX_W   = 8,
  parameter int MEAN_W  = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   sof,
  input  logic                                   data_en,
  input  logic [3*PIX_W-1:0]                     data,
  output logic                                   res_valid,
  input  logic                                   res_ready,
  output logic [$clog2(ZONES_X*ZONES_Y)-1:0]     res_idx,
  output logic [MEAN_W-1:0]                      res_r,
  output logic [MEAN_W-1:0]                      res_g,
  output logic [MEAN_W-1:0]                      res_b,
  output logic                                   res_last,
  output logic                                   frame_done,
  output logic                                   abort_o,
  output logic                                   stray_o,
  output logic                                   busy
);

  localparam int ZW    = IMG_W / ZONES_X;
  localparam int ZH    = IMG_H / ZONES_Y;
  localparam int N     = ZW * ZH;
  localparam int Z     = ZONES_X * ZONES_Y;
  localparam int ACC_W = PIX_W + $clog2(N);
  localparam int IW    = $clog2(Z);
  localparam int SW    = $clog2(3 * Z);
  localparam int DCW   = $clog2(ACC_W + 1);
  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [ACC_W:0] N_V = (ACC_W + 1)'(N);

  if (IMG_W % ZONES_X != 0) begin : g_bad_w
    $error("IMG_W must be a multiple of ZONES_X");
  end
  if (IMG_H % ZONES_Y != 0) begin : g_bad_h
    $error("IMG_H must be a multiple of ZONES_Y");
  end
  if (Z < 2 || IMG_W < 2) begin : g_bad_z
    $error("need at least two zones and two pixels per line");
  end
  if (MEAN_W < 1 || MEAN_W > PIX_W) begin : g_bad_m
    $error("MEAN_W must be in 1..PIX_W");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, OUTPUT} state_t;
  state_t state;

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [ACC_W-1:0]  acc [3*Z];
  logic [MEAN_W-1:0] mean_mem [3*Z];
  logic [SW-1:0]     div_sel;
  logic [DCW-1:0]    div_cnt;
  logic [ACC_W-1:0]  quo;
  logic [ACC_W-1:0]  rem;
  logic [ACC_W:0]    rem_shift;
  logic              div_ge;
  logic [ACC_W-1:0]  next_quo;
  logic [SW-1:0]     zone_base;
  logic [SW-1:0]     nxt_base;
  logic              div_last_step;

  always_comb begin
    zone_base     = SW'(((int'(row) / ZH) * ZONES_X + int'(col) / ZW) * 3);
    nxt_base      = SW'((int'(res_idx) + 1) * 3);
    rem_shift     = {rem, quo[ACC_W-1]};
    div_ge        = (rem_shift >= N_V);
    next_quo      = (quo << 1) | ACC_W'(div_ge);
    div_last_step = (div_cnt == DCW'(ACC_W));
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      div_sel    <= '0;
      div_cnt    <= '0;
      quo        <= '0;
      rem        <= '0;
      res_valid  <= 1'b0;
      res_idx    <= '0;
      res_r      <= '0;
      res_g      <= '0;
      res_b      <= '0;
      res_last   <= 1'b0;
      frame_done <= 1'b0;
      abort_o    <= 1'b0;
      stray_o    <= 1'b0;
      for (int i = 0; i < 3 * Z; i++) acc[i] <= '0;
    end else begin
      frame_done <= 1'b0;
      abort_o    <= 1'b0;
      stray_o    <= 1'b0;
      if (sof) begin
        // A new frame always wins, even over a final handshake in this cycle.
        abort_o   <= (state != IDLE);
        res_valid <= 1'b0;
        res_last  <= 1'b0;
        res_idx   <= '0;
        state     <= ACCUM;
        row       <= '0;
        col       <= '0;
        for (int i = 0; i < 3 * Z; i++) acc[i] <= '0;
        if (data_en) begin
          acc[0] <= ACC_W'(data[3*PIX_W-1 -: PIX_W]);
          acc[1] <= ACC_W'(data[2*PIX_W-1 -: PIX_W]);
          acc[2] <= ACC_W'(data[PIX_W-1:0]);
          col    <= CW'(1);
        end
      end else begin
        case (state)
          IDLE: begin
            if (data_en) stray_o <= 1'b1;
          end
          ACCUM: begin
            if (data_en) begin
              acc[zone_base]           <= acc[zone_base] + ACC_W'(data[3*PIX_W-1 -: PIX_W]);
              acc[zone_base + SW'(1)]  <= acc[zone_base + SW'(1)] + ACC_W'(data[2*PIX_W-1 -: PIX_W]);
              acc[zone_base + SW'(2)]  <= acc[zone_base + SW'(2)] + ACC_W'(data[PIX_W-1:0]);
              if (col == CW'(IMG_W - 1)) begin
                col <= '0;
                if (row == RW'(IMG_H - 1)) begin
                  row     <= '0;
                  state   <= DIVIDE;
                  div_sel <= '0;
                  div_cnt <= '0;
                end else begin
                  row <= row + RW'(1);
                end
              end else begin
                col <= col + CW'(1);
              end
            end
          end
          DIVIDE: begin
            // One load cycle, then ACC_W restoring steps per quotient.
            if (div_cnt == '0) begin
              quo     <= acc[div_sel];
              rem     <= '0;
              div_cnt <= DCW'(1);
            end else begin
              quo <= next_quo;
              rem <= ACC_W'(div_ge ? rem_shift - N_V : rem_shift);
              if (div_last_step) begin
                div_cnt <= '0;
                if (div_sel == SW'(3 * Z - 1)) begin
                  state     <= OUTPUT;
                  res_valid <= 1'b1;
                  res_idx   <= '0;
                  res_r     <= mean_mem[0];
                  res_g     <= mean_mem[1];
                  res_b     <= mean_mem[2];
                  res_last  <= 1'b0;
                end else begin
                  div_sel <= div_sel + SW'(1);
                end
              end else begin
                div_cnt <= div_cnt + DCW'(1);
              end
            end
          end
          OUTPUT: begin
            if (res_ready) begin
              if (res_last) begin
                state      <= IDLE;
                res_valid  <= 1'b0;
                res_last   <= 1'b0;
                frame_done <= 1'b1;
              end else begin
                res_idx  <= res_idx + IW'(1);
                res_r    <= mean_mem[nxt_base];
                res_g    <= mean_mem[nxt_base + SW'(1)];
                res_b    <= mean_mem[nxt_base + SW'(2)];
                res_last <= (res_idx == IW'(Z - 2));
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Mean storage needs no reset: it is always rewritten before OUTPUT reads it.
  always_ff @(posedge clk) begin
    if (state == DIVIDE && !sof && div_cnt != '0 && div_last_step)
      mean_mem[div_sel] <= next_quo[PIX_W-1 -: MEAN_W];
  end

endmodule
